// File: rtl/uart_loader.sv
// Byte-stream frame loader: A5 + addr[4] + data[4] -> one 32-bit memory write.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_loader #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_read,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err,
    output logic [7:0]  pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
`ifdef UART_LOADER_CHECKSUM_EN
        CSUM,
`endif
        REQ
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] idle_q, idle_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pop;
    logic        tmo;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign pop     = rx_read;
    assign tmo     = (idle_q == TIMEOUT - 16'd1);
    assign rx_read = rx_ready && !rst && (state_q != REQ);

    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign pkt_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        idle_d  = 16'd0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (rx_data == 8'hA5) begin
                        state_d = ADDR;
                        idx_d   = 2'd0;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum_d  = 8'h00;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (pop) begin
                    addr_d = {rx_data, addr_q[31:8]};
                    idx_d  = idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (idx_q == 2'd3) state_d = DATA;
                end else if (tmo) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            DATA: begin
                if (pop) begin
                    data_d = {rx_data, data_q[31:8]};
                    idx_d  = idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
                    if (idx_q == 2'd3) state_d = CSUM;
`else
                    // Misaligned frames are drained fully, then dropped.
                    if (idx_q == 2'd3) begin
                        if (addr_q[1:0] != 2'b00) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
                    end
`endif
                end else if (tmo) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CSUM: begin
                if (pop) begin
                    if (rx_data == csum_q && addr_q[1:0] == 2'b00) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
`endif
            REQ: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            idle_q  <= 16'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: expected writes queued, monitor compares.
module tb_uart_loader;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        err;
    logic [7:0]  pkt_cnt;

    int passed = 0;
    int total = 0;
    int err_seen = 0;
    int ack_wait = 0;
    int wcnt = 0;
    logic prev_req = 1'b0;
    logic [63:0] exp_q[$];

    uart_loader #(.TIMEOUT(16'(TMO))) dut (
        .clk(clk),
        .rst(rst),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_read(rx_read),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .busy(busy),
        .err(err),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory responder: acks ack_wait cycles after mem_req appears.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (mem_req) begin
            if (wcnt >= ack_wait) mem_ack = 1'b1;
            else wcnt++;
        end
    end

    // Monitor: compare each new write request against the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mem_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: addr %h data %h",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[63:32]);
                check("wr_data", mem_wdata, e[31:0]);
                check("wr_we", {31'd0, mem_we}, 32'd1);
            end
        end
        prev_req = mem_req;
        if (err) err_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_ready = 1'b1;
        rx_data  = b;
        #1;
        while (!rx_read && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rx_read) begin
            total++;
            $display("FAIL pop_wait: byte %h not consumed", b);
        end
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d,
                              input bit wr);
        logic [7:0] b[10];
        int n;
        b[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            b[1+k] = a[8*k +: 8];
            b[5+k] = d[8*k +: 8];
        end
        b[9] = 8'h00;
        n = 9;
`ifdef UART_LOADER_CHECKSUM_EN
        for (int k = 1; k < 9; k++) b[9] = b[9] ^ b[k];
        n = 10;
`endif
        if (wr) exp_q.push_back({a, d});
        for (int k = 0; k < n; k++) send_byte(b[k]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        #1;
        while (busy && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy) begin
            total++;
            $display("FAIL idle_wait: busy still %b", busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", {24'd0, pkt_cnt}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_data", mem_wdata, 32'h0);
        rx_ready = 1'b1;
        #1;
        check("rst_rxread", {31'd0, rx_read}, 32'd0);
        rx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic write
        send_frame(32'h0000_1000, 32'hDEAD_BEEF, 1);
        wait_idle();
        check("a_cnt", {24'd0, pkt_cnt}, 32'd1);
        check("a_err", err_seen, 32'd0);

        // Junk byte in IDLE then a good frame
        send_byte(8'h3C);
        send_frame(32'h0000_0020, 32'h1234_5678, 1);
        wait_idle();
        check("b_err", err_seen, 32'd1);
        check("b_cnt", {24'd0, pkt_cnt}, 32'd2);

        // Misaligned address: consumed, dropped, err
        send_frame(32'h0000_0001, 32'hCAFE_F00D, 0);
        repeat (3) @(negedge clk);
        check("c_err", err_seen, 32'd2);
        check("c_cnt", {24'd0, pkt_cnt}, 32'd2);
        check("c_busy", {31'd0, busy}, 32'd0);

        // Back-pressure while the request is outstanding
        ack_wait = 25;
        send_frame(32'h0000_0040, 32'hA5A5_0F0F, 1);
        rx_ready = 1'b1;
        rx_data = 8'hA5;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("bp_rxread", {31'd0, rx_read}, 32'd0);
            check("bp_req", {31'd0, mem_req}, 32'd1);
            check("bp_addr", mem_addr, 32'h0000_0040);
            check("bp_data", mem_wdata, 32'hA5A5_0F0F);
            @(negedge clk);
        end
        rx_ready = 1'b0;
        wait_idle();
        ack_wait = 0;
        check("bp_cnt", {24'd0, pkt_cnt}, 32'd3);

        // Inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h00);
        n = 0;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tmo_delay", n, TMO);
        @(negedge clk);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_err", err_seen, 32'd3);

        // Counter wrap
        for (int i = 0; i < 252; i++)
            send_frame(32'h100 + 32'(i) * 4, 32'(i), 1);
        wait_idle();
        check("cnt_ff", {24'd0, pkt_cnt}, 32'hFF);
        send_frame(32'h0000_2000, 32'h0BAD_CAFE, 1);
        wait_idle();
        check("cnt_wrap", {24'd0, pkt_cnt}, 32'h00);

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mr_req", {31'd0, mem_req}, 32'd0);
        check("mr_we", {31'd0, mem_we}, 32'd0);
        check("mr_err", {31'd0, err}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_cnt", {24'd0, pkt_cnt}, 32'd0);
        check("mr_addr", mem_addr, 32'h0);
        check("mr_data", mem_wdata, 32'h0);
        check("mr_rxread", {31'd0, rx_read}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_pending", exp_q.size(), 32'd0);
        check("end_err", err_seen, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
